// File: rtl/cont_disp_mux.sv
// cont_disp_mux: multi-digit hex/BCD up/down counter with synchronous load,
// rollover pulse and a time-multiplexed 7-segment display scanner.
module cont_disp_mux #(
   parameter int DIGITS   = 4,
   parameter int DEC      = 0,
   parameter int SCAN_DIV = 1000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  up,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   output logic [4*DIGITS-1:0]   count,
   output logic                  wrap,
   output logic [7:0]            seg,
   output logic [DIGITS-1:0]     an
);

   localparam int          CW   = 4 * DIGITS;
   localparam int          IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int          PW   = $clog2(SCAN_DIV);
   localparam logic [3:0]  DMAX = (DEC != 0) ? 4'd9 : 4'd15;

   logic [CW-1:0]     count_q, count_d;
   logic              wrap_q, wrap_d;
   logic [PW-1:0]     presc_q, presc_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [DIGITS-1:0] an_q, an_d;
   logic [7:0]        seg_q, seg_d;
   logic              scan_tick;
   logic [3:0]        cur_digit;
   logic [3:0]        nib;
   logic              carry;

   function automatic logic [6:0] decode7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'h0: s = 7'b0111111;
         4'h1: s = 7'b0000110;
         4'h2: s = 7'b1011011;
         4'h3: s = 7'b1001111;
         4'h4: s = 7'b1100110;
         4'h5: s = 7'b1101101;
         4'h6: s = 7'b1111101;
         4'h7: s = 7'b0000111;
         4'h8: s = 7'b1111111;
         4'h9: s = 7'b1101111;
         4'hA: s = 7'b1110111;
         4'hB: s = 7'b1111100;
         4'hC: s = 7'b0111001;
         4'hD: s = 7'b1011110;
         4'hE: s = 7'b1111001;
         default: s = 7'b1110001;
      endcase
      return s;
   endfunction

   // Next count: load (BCD nibbles clamped to 9) wins over counting; the
   // carry/borrow ripples through every digit in one cycle, and a carry out
   // of the top digit is the full-range rollover.
   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      carry   = 1'b1;
      nib     = 4'd0;
      if (load) begin
         for (int i = 0; i < DIGITS; i++) begin
            nib = load_val[4*i +: 4];
            if ((DEC != 0) && (nib > 4'd9)) nib = 4'd9;
            count_d[4*i +: 4] = nib;
         end
      end else if (en) begin
         for (int i = 0; i < DIGITS; i++) begin
            nib = count_q[4*i +: 4];
            if (carry) begin
               if (up) begin
                  if (nib == DMAX) begin
                     nib = 4'd0;
                  end else begin
                     nib   = nib + 4'd1;
                     carry = 1'b0;
                  end
               end else begin
                  if (nib == 4'd0) begin
                     nib = DMAX;
                  end else begin
                     nib   = nib - 4'd1;
                     carry = 1'b0;
                  end
               end
            end
            count_d[4*i +: 4] = nib;
         end
         wrap_d = carry;
      end
   end

   // Scan timing: presc_q holds the cycles remaining on the current digit,
   // so the digit advances every SCAN_DIV cycles starting from reset.
   always_comb begin
      scan_tick = (presc_q == '0);
      presc_d   = scan_tick ? PW'(SCAN_DIV - 1) : presc_q - 1'b1;
      idx_d     = idx_q;
      if (scan_tick) begin
         idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end
   end

   // Display drive for the currently selected digit.
   always_comb begin
      an_d      = '0;
      cur_digit = count_q[3:0];
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_q == IW'(i)) begin
            an_d[i]   = 1'b1;
            cur_digit = count_q[4*i +: 4];
         end
      end
      seg_d = {1'b0, decode7(cur_digit)};
   end

   // All state registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
         presc_q <= PW'(SCAN_DIV - 1);
         idx_q   <= '0;
         an_q    <= DIGITS'(1);
         seg_q   <= 8'b0011_1111;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
         presc_q <= presc_d;
         idx_q   <= idx_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
      end
   end

   assign count = count_q;
   assign wrap  = wrap_q;
   assign seg   = seg_q;
   assign an    = an_q;

endmodule

// File: tb/tb_cont_disp_mux.sv
// Bench for cont_disp_mux: three instances (4-digit hex, 4-digit BCD,
// 2-digit hex) share one stimulus set.
module tb_cont_disp_mux;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, en, up, load;
   logic [15:0] lv;

   logic [15:0] cnt_h, cnt_b;
   logic [7:0]  cnt_2;
   logic        w_h, w_b, w_2;
   logic [7:0]  seg_h, seg_b, seg_2;
   logic [3:0]  an_h, an_b;
   logic [1:0]  an_2;

   int n_cmp = 0;
   int n_err = 0;

   cont_disp_mux #(.DIGITS(4), .DEC(0), .SCAN_DIV(4)) u_hex (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv),
      .count(cnt_h), .wrap(w_h), .seg(seg_h), .an(an_h));

   cont_disp_mux #(.DIGITS(4), .DEC(1), .SCAN_DIV(4)) u_bcd (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv),
      .count(cnt_b), .wrap(w_b), .seg(seg_b), .an(an_b));

   cont_disp_mux #(.DIGITS(2), .DEC(0), .SCAN_DIV(4)) u_hex2 (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv[7:0]),
      .count(cnt_2), .wrap(w_2), .seg(seg_2), .an(an_2));

   typedef struct {
      logic        rst, load, en, up;
      logic [15:0] lv, exp_h, exp_b;
      logic        w_h, w_b;
   } vec_t;

   vec_t vt[17];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic        found;
      logic        an_moved;
      logic [3:0]  an_first;
      logic [3:0]  exp_an;
      logic [7:0]  exp_seg;
      logic [7:0]  seg_tab [4];

      //          rst load en up  lv        hex       bcd       wh wb
      vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
      vt[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0999, 16'h0999, 16'h0999, 1'b0, 1'b0};
      vt[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h099A, 16'h1000, 1'b0, 1'b0};
      vt[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h00AF, 16'h00AF, 16'h0099, 1'b0, 1'b0};
      vt[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h00B0, 16'h0100, 1'b0, 1'b0};
      vt[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
      vt[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'hFFFF, 16'h9999, 1'b1, 1'b1};
      vt[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'hFFFE, 16'h9998, 1'b0, 1'b0};
      vt[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h1234, 16'h1234, 16'h1234, 1'b0, 1'b0};
      vt[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h5678, 16'h0000, 16'h0000, 1'b0, 1'b0};
      vt[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFE, 16'hFFFE, 16'h9999, 1'b0, 1'b0};
      vt[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'hFFFF, 16'h0000, 1'b0, 1'b1};
      vt[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0001, 1'b1, 1'b0};
      vt[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0001, 16'h0002, 1'b0, 1'b0};
      vt[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0001, 16'h0002, 1'b0, 1'b0};
      vt[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0001, 1'b0, 1'b0};
      vt[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'hFFFF, 16'h0000, 1'b1, 1'b0};

      rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; lv = 16'h0000;
      step();
      chk("reset_an", {28'd0, an_h}, 32'h1);
      chk("reset_seg", {24'd0, seg_h}, 32'h3F);
      chk("reset_an2", {30'd0, an_2}, 32'h1);

      for (int i = 0; i < 17; i++) begin
         rst = vt[i].rst; load = vt[i].load; en = vt[i].en; up = vt[i].up; lv = vt[i].lv;
         step();
         chk($sformatf("vec%0d_hex_count", i), {16'd0, cnt_h}, {16'd0, vt[i].exp_h});
         chk($sformatf("vec%0d_bcd_count", i), {16'd0, cnt_b}, {16'd0, vt[i].exp_b});
         chk($sformatf("vec%0d_hex_wrap", i), {31'd0, w_h}, {31'd0, vt[i].w_h});
         chk($sformatf("vec%0d_bcd_wrap", i), {31'd0, w_b}, {31'd0, vt[i].w_b});
      end

      // 2-digit hex rollover: FE -> FF -> 00 (wrap) -> 01
      rst = 1'b0; en = 1'b0; load = 1'b1; up = 1'b1; lv = 16'h00FE;
      step();
      chk("hex2_load", {24'd0, cnt_2}, 32'hFE);
      load = 1'b0; en = 1'b1;
      step();
      chk("hex2_ff", {24'd0, cnt_2}, 32'hFF);
      chk("hex2_ff_wrap", {31'd0, w_2}, 32'h0);
      step();
      chk("hex2_00", {24'd0, cnt_2}, 32'h00);
      chk("hex2_00_wrap", {31'd0, w_2}, 32'h1);
      step();
      chk("hex2_01", {24'd0, cnt_2}, 32'h01);
      chk("hex2_01_wrap", {31'd0, w_2}, 32'h0);

      // Hold for 20 cycles with 3A71 loaded; display keeps scanning
      en = 1'b0; load = 1'b1; lv = 16'h3A71;
      step();
      load = 1'b0;
      an_first = an_h;
      an_moved = 1'b0;
      for (int c = 0; c < 20; c++) begin
         step();
         chk("hold_count", {16'd0, cnt_h}, 32'h3A71);
         chk("hold_wrap", {31'd0, w_h}, 32'h0);
         chk("hold_onehot", {31'd0, $onehot(an_h)}, 32'h1);
         if (an_h != an_first) an_moved = 1'b1;
      end
      chk("hold_an_scans", {31'd0, an_moved}, 32'h1);

      // Scan order and segment patterns for 3A71
      seg_tab[0] = 8'b0000_0110;
      seg_tab[1] = 8'b0000_0111;
      seg_tab[2] = 8'b0111_0111;
      seg_tab[3] = 8'b0100_1111;
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         if (an_h == 4'b0010) found = 1'b1;
         else step();
      end
      chk("scan_find_digit1", {31'd0, found}, 32'h1);
      if (found) begin
         for (int k = 0; k < 16; k++) begin
            exp_an  = 4'b0001 << ((k / 4 + 1) % 4);
            exp_seg = seg_tab[(k / 4 + 1) % 4];
            chk($sformatf("scan_an_%0d", k), {28'd0, an_h}, {28'd0, exp_an});
            chk($sformatf("scan_seg_%0d", k), {24'd0, seg_h}, {24'd0, exp_seg});
            step();
         end
      end

      // Reset mid-count/mid-scan with load and en active
      en = 1'b1; up = 1'b1;
      step();
      step();
      rst = 1'b1; load = 1'b1; lv = 16'h1111;
      step();
      chk("midrst_count", {16'd0, cnt_h}, 32'h0);
      chk("midrst_bcd", {16'd0, cnt_b}, 32'h0);
      chk("midrst_wrap", {31'd0, w_h}, 32'h0);
      chk("midrst_an", {28'd0, an_h}, 32'h1);
      chk("midrst_seg", {24'd0, seg_h}, 32'h3F);
      rst = 1'b0; load = 1'b0; en = 1'b0;
      step();
      chk("postrst_an", {28'd0, an_h}, 32'h1);
      chk("postrst_seg", {24'd0, seg_h}, 32'h3F);
      chk("postrst_count", {16'd0, cnt_h}, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
